fa: RTL and testbench



---
 rtl/fa_pkg.sv | 7 +
 rtl/fa_cell.sv | 13 +
 rtl/fa.sv | 56 +++++
 tb/tb_fa.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared defaults for the ripple-carry full-adder block.
package fa_pkg;

  localparam int FA_WIDTH = 1;
  localparam int FA_CNT_W = 8;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder: the leaf cell of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa.sv
// WIDTH-bit ripple-carry adder with combinational sum/carry, registered copies
// of both, and a saturating count of cycles whose carry-out was set.
module fa
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH,
  parameter int CNT_W = FA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [WIDTH-1:0] S_q,
  output logic             Cout_q,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  // c[i] is the carry into bit i; c[WIDTH] leaves the MSB.
  logic [WIDTH:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

  assign Cout = c[WIDTH];

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so S_q and carry_cnt both see the same settled Cout regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q       <= '0;
      Cout_q    <= 1'b0;
      carry_cnt <= '0;
    end else begin
      S_q    <= S;
      Cout_q <= Cout;
      if (Cout && (carry_cnt != '1)) begin
        carry_cnt <= carry_cnt + CNT_INC;
      end
    end
  end

endmodule

// File: tb/tb_fa.sv
// Directed bench for fa: truth table, registered path, async reset, counter
// saturation and an 8-bit random sweep, checked against a scoreboard queue.
module tb_fa;

  logic clk = 1'b0;
  logic rst;

  // WIDTH=1, CNT_W=8
  logic       a1, b1, c1;
  logic       s1, co1, sq1, coq1;
  logic [7:0] cnt1;

  // WIDTH=1, CNT_W=2
  logic       a2, b2, c2;
  logic       s2, co2, sq2, coq2;
  logic [1:0] cnt2;

  // WIDTH=8, CNT_W=8
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] s8, sq8;
  logic       co8, coq8;
  logic [7:0] cnt8;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] sb_q[$];

  fa #(.WIDTH(1), .CNT_W(8)) u_fa1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1),
    .S(s1), .Cout(co1), .S_q(sq1), .Cout_q(coq1), .carry_cnt(cnt1)
  );

  fa #(.WIDTH(1), .CNT_W(2)) u_fa2 (
    .clk(clk), .rst(rst), .A(a2), .B(b2), .Cin(c2),
    .S(s2), .Cout(co2), .S_q(sq2), .Cout_q(coq2), .carry_cnt(cnt2)
  );

  fa #(.WIDTH(8), .CNT_W(8)) u_fa8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8),
    .S(s8), .Cout(co8), .S_q(sq8), .Cout_q(coq8), .carry_cnt(cnt8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, obs);
    end else begin
      check(tag, obs, sb_q.pop_front());
    end
  endtask

  // Returns one time unit after a rising edge, well away from the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [2:0]  v;
    logic [1:0]  e2;
    logic [8:0]  e9;
    logic [7:0]  ba [3];
    logic [7:0]  bb [3];
    logic        bc [3];
    logic [8:0]  bexp [3];

    rst = 1'b1;
    a1 = 0; b1 = 0; c1 = 0;
    a2 = 0; b2 = 0; c2 = 0;
    a8 = '0; b8 = '0; c8 = 0;

    // Reset state, held across an edge.
    #12;
    check("rst_sq1",   32'(sq1),  32'd0);
    check("rst_coq1",  32'(coq1), 32'd0);
    check("rst_cnt1",  32'(cnt1), 32'd0);
    check("rst_sq8",   32'(sq8),  32'd0);
    check("rst_cnt2",  32'(cnt2), 32'd0);
    rst = 1'b0;

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, c1} = v;
      #10;
      e2 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      check($sformatf("tt_s_%0d", i),    32'(s1),  32'(e2[0]));
      check($sformatf("tt_cout_%0d", i), 32'(co1), 32'(e2[1]));
    end

    // Registered path.
    tick();
    rst_pulse();
    {a1, b1, c1} = 3'b111;
    sb_q.push_back(32'b11);
    tick();
    check_pop("reg_111", 32'({coq1, sq1}));
    {a1, b1, c1} = 3'b000;
    sb_q.push_back(32'b00);
    tick();
    check_pop("reg_000", 32'({coq1, sq1}));

    // Async reset between edges with counter at 3.
    rst_pulse();
    {a1, b1, c1} = 3'b111;
    repeat (3) tick();
    check("pre_rst_sq1",  32'(sq1),  32'd1);
    check("pre_rst_cnt1", 32'(cnt1), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_sq1",   32'(sq1),  32'd0);
    check("arst_coq1",  32'(coq1), 32'd0);
    check("arst_cnt1",  32'(cnt1), 32'd0);
    check("arst_s1",    32'(s1),   32'd1);
    check("arst_cout1", 32'(co1),  32'd1);
    #1 rst = 1'b0;

    // Counter saturation on the CNT_W=2 instance.
    tick();
    {a2, b2, c2} = 3'b110;
    sb_q.push_back(32'd1);
    sb_q.push_back(32'd2);
    sb_q.push_back(32'd3);
    sb_q.push_back(32'd3);
    sb_q.push_back(32'd3);
    repeat (5) begin
      tick();
      check_pop("sat_cnt2", 32'(cnt2));
    end

    // WIDTH=8 boundaries.
    ba[0] = 8'hFF; bb[0] = 8'h00; bc[0] = 1'b1; bexp[0] = {1'b1, 8'h00};
    ba[1] = 8'h80; bb[1] = 8'h80; bc[1] = 1'b0; bexp[1] = {1'b1, 8'h00};
    ba[2] = 8'h5A; bb[2] = 8'h25; bc[2] = 1'b0; bexp[2] = {1'b0, 8'h7F};
    for (int i = 0; i < 3; i++) begin
      a8 = ba[i]; b8 = bb[i]; c8 = bc[i];
      #1;
      check($sformatf("bnd_comb_%0d", i), 32'({co8, s8}), 32'(bexp[i]));
      sb_q.push_back(32'(bexp[i]));
      tick();
      check_pop($sformatf("bnd_reg_%0d", i), 32'({coq8, sq8}));
    end

    // WIDTH=8 random sweep.
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      e9 = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
      #1;
      check("rnd_comb", 32'({co8, s8}), 32'(e9));
      sb_q.push_back(32'(e9[7:0]));
      tick();
      check_pop("rnd_sq", 32'(sq8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
